// File: rtl/store_retire_queue_pkg.sv
// Shared types and defaults for the retired-store queue.
//   sq_entry_t  : one queued store (valid, address, data, byte enables) at default widths
//   sq_state_e  : drain FSM states
//   SQ_*_DEF    : default parameter values
package store_retire_queue_pkg;

   localparam int SQ_DEPTH_DEF  = 4;
   localparam int SQ_ADDR_W_DEF = 32;
   localparam int SQ_DATA_W_DEF = 32;

   typedef struct packed {
      logic                           valid;
      logic [SQ_ADDR_W_DEF-1:0]       addr;
      logic [SQ_DATA_W_DEF-1:0]       data;
      logic [SQ_DATA_W_DEF/8-1:0]     be;
   } sq_entry_t;

   typedef enum logic {
      SQ_IDLE = 1'b0,
      SQ_REQ  = 1'b1
   } sq_state_e;

endpackage

// File: rtl/store_retire_queue_cam.sv
// sq_addr_cam: word-granular load-vs-store address comparator.
//   entry_valid   in  DEPTH          valid bit per queue slot
//   entry_word    in  DEPTH x WORD_W word address (byte address >> 2) per slot
//   push_valid    in  1              a store is being written this cycle
//   push_word     in  WORD_W         word address of the store being written
//   ld_word       in  WORD_W         word address of the load under test
//   ld_conflict   out 1              load word matches any valid slot or the incoming store
module sq_addr_cam
   import store_retire_queue_pkg::*;
#(
   parameter int DEPTH  = SQ_DEPTH_DEF,
   parameter int WORD_W = SQ_ADDR_W_DEF - 2
) (
   input  logic [DEPTH-1:0]             entry_valid,
   input  logic [DEPTH-1:0][WORD_W-1:0] entry_word,
   input  logic                         push_valid,
   input  logic [WORD_W-1:0]            push_word,
   input  logic [WORD_W-1:0]            ld_word,
   output logic                         ld_conflict
);

   always_comb begin
      ld_conflict = push_valid && (push_word == ld_word);
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (entry_word[i] == ld_word)) begin
            ld_conflict = 1'b1;
         end
      end
   end

endmodule

// File: rtl/store_retire_queue.sv
// store_retire_queue: in-order buffer of committed stores, drained one at a time
// to data memory over a req/ack handshake. Entries are never flushed.
//   i_clk, i_rst                       clock, synchronous active-high reset
//   retire_valid/addr/data/be, ready   push side; push = retire_valid & retire_ready
//   dmem_req/addr/wdata/be, dmem_ack   drain side; pop = dmem_req & dmem_ack
//   ld_check_addr, ld_conflict         load word overlap check against pending stores
//   sq_count, sq_empty                 occupancy
module store_retire_queue
   import store_retire_queue_pkg::*;
#(
   parameter int DEPTH  = SQ_DEPTH_DEF,
   parameter int ADDR_W = SQ_ADDR_W_DEF,
   parameter int DATA_W = SQ_DATA_W_DEF
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       retire_valid,
   input  logic [ADDR_W-1:0]          retire_addr,
   input  logic [DATA_W-1:0]          retire_data,
   input  logic [DATA_W/8-1:0]        retire_be,
   output logic                       retire_ready,
   output logic                       dmem_req,
   output logic [ADDR_W-1:0]          dmem_addr,
   output logic [DATA_W-1:0]          dmem_wdata,
   output logic [DATA_W/8-1:0]        dmem_be,
   input  logic                       dmem_ack,
   input  logic [ADDR_W-1:0]          ld_check_addr,
   output logic                       ld_conflict,
   output logic [$clog2(DEPTH):0]     sq_count,
   output logic                       sq_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = DATA_W / 8;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0]                  head_q, head_d;
   logic [PW-1:0]                  tail_q, tail_d;
   logic [CW-1:0]                  count_q, count_d;
   logic [DEPTH-1:0]               valid_q, valid_d;
   logic [DEPTH-1:0][ADDR_W-1:0]   addr_q, addr_d;
   logic [DEPTH-1:0][DATA_W-1:0]   data_q, data_d;
   logic [DEPTH-1:0][BW-1:0]       be_q, be_d;
   sq_state_e                      state_q, state_d;

   logic push;
   logic pop;

   // Pop readiness never feeds back into ready: a full queue refuses the push
   // even when the head leaves in the same cycle.
   assign retire_ready = (count_q != FULL);
   assign push         = retire_valid & retire_ready;
   assign dmem_req     = (state_q == SQ_REQ);
   assign pop          = dmem_req & dmem_ack;
   assign sq_count     = count_q;
   assign sq_empty     = (count_q == '0);

   always_comb begin
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_be    = '0;
      if (dmem_req) begin
         dmem_addr  = addr_q[head_q];
         dmem_wdata = data_q[head_q];
         dmem_be    = be_q[head_q];
      end
   end

   // Pointer, occupancy and storage update.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PW'(1);
      end
      if (push) begin
         valid_d[tail_q] = 1'b1;
         addr_d[tail_q]  = retire_addr;
         data_d[tail_q]  = retire_data;
         be_d[tail_q]    = retire_be;
         tail_d          = tail_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Drain FSM. Deciding on the post-edge occupancy gives the one-cycle
   // push-to-request latency and back-to-back drains without an idle bubble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SQ_IDLE: if (count_d != '0) state_d = SQ_REQ;
         SQ_REQ:  if (pop && (count_d == '0)) state_d = SQ_IDLE;
         default: state_d = SQ_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         state_q <= SQ_IDLE;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         state_q <= state_d;
      end
   end

   // Payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge i_clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
      be_q   <= be_d;
   end

   logic [DEPTH-1:0][ADDR_W-3:0] entry_word;
   logic                         ld_lo_unused;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_word[i] = addr_q[i][ADDR_W-1:2];
      end
   end

   // Word granularity: byte offset of the load address is irrelevant.
   assign ld_lo_unused = ^ld_check_addr[1:0];

   sq_addr_cam #(
      .DEPTH  (DEPTH),
      .WORD_W (ADDR_W - 2)
   ) u_cam (
      .entry_valid (valid_q),
      .entry_word  (entry_word),
      .push_valid  (push),
      .push_word   (retire_addr[ADDR_W-1:2]),
      .ld_word     (ld_check_addr[ADDR_W-1:2]),
      .ld_conflict (ld_conflict)
   );

endmodule

// File: tb/tb_store_retire_queue.sv
module tb_store_retire_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv;
   logic [31:0] raddr;
   logic [31:0] rdata;
   logic [3:0]  rbe;
   logic        rready;
   logic        req;
   logic [31:0] maddr;
   logic [31:0] mdata;
   logic [3:0]  mbe;
   logic        ack;
   logic [31:0] ld;
   logic        conflict;
   logic [2:0]  count;
   logic        empty;

   always #5 clk = ~clk;

   store_retire_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .retire_valid  (rv),
      .retire_addr   (raddr),
      .retire_data   (rdata),
      .retire_be     (rbe),
      .retire_ready  (rready),
      .dmem_req      (req),
      .dmem_addr     (maddr),
      .dmem_wdata    (mdata),
      .dmem_be       (mbe),
      .dmem_ack      (ack),
      .ld_check_addr (ld),
      .ld_conflict   (conflict),
      .sq_count      (count),
      .sq_empty      (empty)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   ent_t mq[$];
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the queue contents after each edge, from the push/pop rules.
   int  m_n;
   bit  m_pop, m_push;
   always @(posedge clk) begin
      m_n = mq.size();
      if (rst) begin
         mq.delete();
      end else begin
         m_pop  = (m_n != 0) && ack;
         m_push = rv && (m_n != DEPTH);
         if (m_pop) void'(mq.pop_front());
         if (m_push) mq.push_back('{raddr, rdata, rbe});
      end
   end

   // Every-cycle comparison against the model.
   int          c_n;
   bit          e_req, e_cf;
   logic [31:0] e_a, e_d;
   logic [3:0]  e_be;
   always @(negedge clk) begin
      if (chk_en) begin
         c_n   = mq.size();
         e_req = (c_n != 0);
         e_a   = e_req ? mq[0].a  : 32'h0;
         e_d   = e_req ? mq[0].d  : 32'h0;
         e_be  = e_req ? mq[0].be : 4'h0;
         e_cf  = rv && (c_n != DEPTH) && (raddr[31:2] == ld[31:2]);
         foreach (mq[i]) if (mq[i].a[31:2] == ld[31:2]) e_cf = 1'b1;
         chk("m_ready", rready, c_n != DEPTH);
         chk("m_req",   req,    e_req);
         chk("m_addr",  maddr,  e_a);
         chk("m_wdata", mdata,  e_d);
         chk("m_be",    mbe,    e_be);
         chk("m_count", count,  c_n);
         chk("m_empty", empty,  c_n == 0);
         chk("m_conf",  conflict, e_cf);
      end
   end

   logic [31:0] sd [0:3];

   initial begin
      rst = 1'b1; rv = 1'b0; raddr = '0; rdata = '0; rbe = '0; ack = 1'b1; ld = '0;
      cyc();
      chk_en = 1'b1;
      #1;
      chk("rst_req",   req,      1'b0);
      chk("rst_ready", rready,   1'b1);
      chk("rst_count", count,    3'd0);
      chk("rst_empty", empty,    1'b1);
      chk("rst_addr",  maddr,    32'h0);
      chk("rst_conf",  conflict, 1'b0);
      cyc();

      // 1: single store with ack tied high
      rst = 1'b0; rv = 1'b1; raddr = 32'h100; rdata = 32'hDEADBEEF; rbe = 4'hF; ack = 1'b1;
      cyc();
      rv = 1'b0;
      #1;
      chk("s1_req",  req,   1'b1);
      chk("s1_addr", maddr, 32'h100);
      chk("s1_data", mdata, 32'hDEADBEEF);
      chk("s1_be",   mbe,   4'hF);
      cyc();
      #1;
      chk("s1_empty", empty, 1'b1);
      chk("s1_req0",  req,   1'b0);

      // 2: fill with ack low, fifth store refused
      ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rv = 1'b1; raddr = 32'h1000 + 32'(4 * i); sd[i] = $urandom; rdata = sd[i]; rbe = 4'(i + 1);
         cyc();
      end
      raddr = 32'h1010; rdata = 32'h55AA55AA;
      #1;
      chk("s2_ready", rready, 1'b0);
      chk("s2_count", count,  3'd4);
      cyc();
      #1;
      chk("s2_count5", count, 3'd4);

      // 3: full, ack and retire together -> pop only, push next cycle
      ack = 1'b1; raddr = 32'h1020; rdata = 32'h12345678; rbe = 4'h3;
      cyc();
      ack = 1'b0;
      #1;
      chk("s3_count", count,  3'd3);
      chk("s3_ready", rready, 1'b1);
      cyc();
      rv = 1'b0;
      #1;
      chk("s3_count4", count, 3'd4);

      // 4: head held stable across 5 unacked cycles, next head after ack
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("s4_addr", maddr, 32'h1004);
         chk("s4_data", mdata, sd[1]);
         chk("s4_be",   mbe,   4'h2);
         cyc();
      end
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      #1;
      chk("s4_next_addr", maddr, 32'h1008);
      chk("s4_next_data", mdata, sd[2]);
      ack = 1'b1;
      repeat (5) cyc();
      #1;
      chk("s4_drained", empty, 1'b1);

      // 5: load conflict checks
      ack = 1'b0;
      rv = 1'b1; raddr = 32'h200; rdata = 32'h1; rbe = 4'hF;
      cyc();
      raddr = 32'h304;
      cyc();
      rv = 1'b0; ld = 32'h203;
      #1;
      chk("s5_203", conflict, 1'b1);
      ld = 32'h308;
      #1;
      chk("s5_308", conflict, 1'b0);
      ld = 32'h400; rv = 1'b1; raddr = 32'h400;
      #1;
      chk("s5_400", conflict, 1'b1);
      cyc();
      rv = 1'b0; ack = 1'b1;
      repeat (5) cyc();

      // 6: randomized traffic through many wraps
      for (int n = 0; n < 3000; n++) begin
         rv    = ($urandom_range(0, 99) < 55);
         ack   = ($urandom_range(0, 99) < 50);
         raddr = 32'h8000 + 32'($urandom_range(0, 31));
         rdata = $urandom;
         rbe   = 4'($urandom_range(0, 15));
         ld    = 32'h8000 + 32'($urandom_range(0, 31));
         cyc();
      end

      // reset while a request is outstanding
      ack = 1'b0; rv = 1'b1; raddr = 32'h900;
      cyc();
      cyc();
      rv = 1'b0;
      #1;
      chk("s6_req_pre", req, 1'b1);
      rst = 1'b1; ack = 1'b1;
      cyc();
      rst = 1'b0; ack = 1'b0;
      #1;
      chk("s6_rst_req",   req,   1'b0);
      chk("s6_rst_count", count, 3'd0);
      repeat (3) cyc();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
